// File: rtl/rtc_pkg.sv
// ---------------------------------------------------------------------------
// rtc_pkg
// Shared definitions for the uPD4990 serial master: FSM state encoding,
// frame geometry (40 data bits followed by 4 command bits), the uPD4990
// command codes and a helper that picks the first bit of a frame.
// ---------------------------------------------------------------------------
package rtc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BIT_LO = 3'd1,
    BIT_HI = 3'd2,
    STB_HI = 3'd3,
    STB_LO = 3'd4
  } rtc_state_e;

  localparam int DATA_BITS  = 40;
  localparam int CMD_BITS   = 4;
  localparam int FRAME_BITS = DATA_BITS + CMD_BITS;

  // uPD4990 command codes (C3..C0)
  localparam logic [3:0] CMD_REG_HOLD   = 4'd0;
  localparam logic [3:0] CMD_REG_SHIFT  = 4'd1;
  localparam logic [3:0] CMD_TIME_SET   = 4'd2;
  localparam logic [3:0] CMD_TIME_READ  = 4'd3;
  localparam logic [3:0] CMD_TP_64HZ    = 4'd4;
  localparam logic [3:0] CMD_TP_256HZ   = 4'd5;
  localparam logic [3:0] CMD_TP_2048HZ  = 4'd6;
  localparam logic [3:0] CMD_TEST       = 4'd7;

  // Frame bit positions: data occupies 0..39, command 40..43.
  localparam logic [5:0] CMD_START_IDX = 6'd40;
  localparam logic [5:0] LAST_BIT_IDX  = 6'd43;

  // STB_LO runs three phases (counted 0..2) before DONE.
  localparam logic [1:0] STB_LO_LAST = 2'd2;

  // A full frame starts at data bit 0, a command-only frame at the command.
  function automatic logic [5:0] first_bit_idx(input logic full);
    if (full) begin
      return 6'd0;
    end else begin
      return CMD_START_IDX;
    end
  endfunction

endpackage

// File: rtl/rtc_serial_ctrl_sync2.sv
// ---------------------------------------------------------------------------
// sync2
// Two-flop synchronizer bringing an asynchronous RTC pin into the system
// clock domain. Both flops clear on the synchronous reset.
// Ports:
//   clk - system clock
//   rst - synchronous active-high reset
//   d   - asynchronous input
//   q   - synchronized output (two clocks of latency)
// ---------------------------------------------------------------------------
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  // Next-state of the two synchronizer stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/rtc_serial_ctrl.sv
// ---------------------------------------------------------------------------
// rtc_serial_ctrl
// Serial master for the uPD4990 RTC. A single START handshake latches a
// command (and optionally 40 bits of time data) and the block shifts the
// frame out LSB first on RTC_CLK/RTC_DATA_IN, strobes the command in with
// RTC_STROBE, captures RTC_DATA_OUT into RD_DATA on full transactions and
// flags rising edges of the RTC timing pulse.
// Ports:
//   CLK, RESET        - system clock, synchronous active-high reset
//   START/FULL/CMD/WR_DATA - request interface (START honoured when BUSY=0)
//   BUSY/DONE/RD_DATA - status: busy flag, end pulse, captured read data
//   TP_RISE           - one-cycle pulse per synchronized RTC_TP rising edge
//   RTC_CS/OE/CLK/DATA_IN/STROBE - registered pins toward the RTC
//   RTC_DATA_OUT/RTC_TP          - asynchronous pins from the RTC
// ---------------------------------------------------------------------------
module rtc_serial_ctrl
  import rtc_pkg::*;
#(
  parameter int CLK_DIV = 12
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic                 FULL,
  input  logic [CMD_BITS-1:0]  CMD,
  input  logic [DATA_BITS-1:0] WR_DATA,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [DATA_BITS-1:0] RD_DATA,
  output logic                 TP_RISE,
  output logic                 RTC_CS,
  output logic                 RTC_OE,
  output logic                 RTC_CLK,
  output logic                 RTC_DATA_IN,
  output logic                 RTC_STROBE,
  input  logic                 RTC_DATA_OUT,
  input  logic                 RTC_TP
);

  localparam int              PH_W    = $clog2(CLK_DIV);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);

  rtc_state_e             state_q, state_d;
  logic [PH_W-1:0]        phase_q, phase_d;
  logic [5:0]             bit_idx_q, bit_idx_d;
  logic [1:0]             tail_q, tail_d;
  logic                   full_q, full_d;
  logic [FRAME_BITS-1:0]  frame_q, frame_d;
  logic [DATA_BITS-1:0]   cap_q, cap_d;
  logic [DATA_BITS-1:0]   rd_data_q, rd_data_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   cs_q, cs_d;
  logic                   oe_q, oe_d;
  logic                   sclk_q, sclk_d;
  logic                   din_q, din_d;
  logic                   stb_q, stb_d;
  logic                   tp_prev_q, tp_prev_d;
  logic                   tp_rise_q, tp_rise_d;

  logic                   data_out_s;
  logic                   tp_s;
  logic                   phase_end_s;
  logic                   start_ok_s;

  sync2 u_sync_data_out (
    .clk (CLK),
    .rst (RESET),
    .d   (RTC_DATA_OUT),
    .q   (data_out_s)
  );

  sync2 u_sync_tp (
    .clk (CLK),
    .rst (RESET),
    .d   (RTC_TP),
    .q   (tp_s)
  );

  // Next-state logic: FSM, phase/bit counters, frame/capture registers and
  // the pin values for the coming cycle (all outputs are registered).
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_idx_d = bit_idx_q;
    tail_d    = tail_q;
    full_d    = full_q;
    frame_d   = frame_q;
    cap_d     = cap_q;
    rd_data_d = rd_data_q;
    done_d    = 1'b0;
    oe_d      = 1'b1;

    phase_end_s = (phase_q == PH_LAST);
    // BUSY stays high through the DONE cycle, so a START coincident with
    // DONE is dropped as well.
    start_ok_s  = START && (state_q == IDLE) && !busy_q;

    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (start_ok_s) begin
          state_d   = BIT_LO;
          frame_d   = {CMD, WR_DATA};
          full_d    = FULL;
          bit_idx_d = first_bit_idx(FULL);
          tail_d    = 2'd0;
        end else begin
          state_d = IDLE;
        end
      end

      BIT_LO: begin
        if (phase_end_s) begin
          phase_d = '0;
          state_d = BIT_HI;
          // Sample just before RTC_CLK rises; the RTC has had the whole low
          // phase to settle the bit it drove on the previous rise.
          if (full_q && (bit_idx_q < CMD_START_IDX)) begin
            cap_d = {data_out_s, cap_q[DATA_BITS-1:1]};
          end else begin
            cap_d = cap_q;
          end
        end else begin
          phase_d = phase_q + PH_ONE;
        end
      end

      BIT_HI: begin
        if (phase_end_s) begin
          phase_d = '0;
          if (bit_idx_q == LAST_BIT_IDX) begin
            state_d = STB_HI;
          end else begin
            state_d   = BIT_LO;
            bit_idx_d = bit_idx_q + 6'd1;
          end
        end else begin
          phase_d = phase_q + PH_ONE;
        end
      end

      STB_HI: begin
        if (phase_end_s) begin
          phase_d = '0;
          state_d = STB_LO;
          tail_d  = 2'd0;
        end else begin
          phase_d = phase_q + PH_ONE;
        end
      end

      STB_LO: begin
        // CS is held for three phases after the strobe falls, so START to
        // DONE spans N+2 full RTC_CLK periods.
        if (phase_end_s) begin
          phase_d = '0;
          if (tail_q == STB_LO_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (full_q) begin
              rd_data_d = cap_q;
            end else begin
              rd_data_d = rd_data_q;
            end
          end else begin
            tail_d = tail_q + 2'd1;
          end
        end else begin
          phase_d = phase_q + PH_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase

    // Pin values follow the state being entered.
    cs_d   = (state_d != IDLE);
    sclk_d = (state_d == BIT_HI);
    stb_d  = (state_d == STB_HI);
    busy_d = (state_d != IDLE) || done_d;
    if ((state_d == BIT_LO) || (state_d == BIT_HI)) begin
      din_d = frame_d[bit_idx_d];
    end else begin
      din_d = 1'b0;
    end

    tp_prev_d = tp_s;
    tp_rise_d = tp_s && !tp_prev_q;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      bit_idx_q <= 6'd0;
      tail_q    <= 2'd0;
      full_q    <= 1'b0;
      frame_q   <= '0;
      cap_q     <= '0;
      rd_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cs_q      <= 1'b0;
      oe_q      <= 1'b1;
      sclk_q    <= 1'b0;
      din_q     <= 1'b0;
      stb_q     <= 1'b0;
      tp_prev_q <= 1'b0;
      tp_rise_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_idx_q <= bit_idx_d;
      tail_q    <= tail_d;
      full_q    <= full_d;
      frame_q   <= frame_d;
      cap_q     <= cap_d;
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cs_q      <= cs_d;
      oe_q      <= oe_d;
      sclk_q    <= sclk_d;
      din_q     <= din_d;
      stb_q     <= stb_d;
      tp_prev_q <= tp_prev_d;
      tp_rise_q <= tp_rise_d;
    end
  end

  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign RD_DATA     = rd_data_q;
  assign TP_RISE     = tp_rise_q;
  assign RTC_CS      = cs_q;
  assign RTC_OE      = oe_q;
  assign RTC_CLK     = sclk_q;
  assign RTC_DATA_IN = din_q;
  assign RTC_STROBE  = stb_q;

endmodule
